// File: rtl/bintobcd_seq.sv
// ---------------------------------------------------------------------------
// bintobcd_seq
//
// Sequential signed-binary to 7-segment display-code converter. A signed
// two's-complement value is split into sign and magnitude. The magnitude is
// then turned into BCD by shift-add-3 (double dabble), one shift per clock.
// The finished digits are formatted with leading-zero blanking, a minus sign
// and an overflow 'E' pattern. The formatted codes are held between
// conversions.
//
// Display codes: 0-9 digit, 4'b1011 minus, 4'b1111 blank, 4'b1110 'E'.
//
// Ports
//   clk    in   1     system clock, rising edge
//   rst_n  in   1     asynchronous active-low reset
//   start  in   1     conversion request, only looked at while idle
//   binin  in   BITS  signed input, captured on the accepted start
//   busy   out  1     conversion in progress
//   done   out  1     one-cycle pulse, outputs valid from the same edge
//   ovf    out  1     last converted magnitude exceeded MAXMAG
//   BCD0   out  4     ones digit
//   BCD1   out  4     tens digit or blank
//   BCD2   out  4     hundreds digit or blank
//   BCD3   out  4     sign (minus or blank)
// ---------------------------------------------------------------------------
module bintobcd_seq #(
    parameter int BITS   = 11,
    parameter int MAXMAG = 999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] binin,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      BCD0,
    output logic [3:0]      BCD1,
    output logic [3:0]      BCD2,
    output logic [3:0]      BCD3
);

    // Four BCD nibbles hold the largest magnitude, 2**(BITS-1) (1024 for 11 bits).
    localparam int NDIG = 4;
    localparam int BCDW = 4 * NDIG;
    localparam int CNTW = $clog2(BITS + 1);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BITS - 1);
    localparam logic [BITS:0]   MAXMAG_L = (BITS + 1)'(MAXMAG);

    localparam logic [3:0] CODE_MINUS = 4'b1011;
    localparam logic [3:0] CODE_BLANK = 4'b1111;
    localparam logic [3:0] CODE_ERR   = 4'b1110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [BITS-1:0] magin_q, magin_d;   // captured magnitude, kept for the range test
    logic [BITS-1:0] mag_q, mag_d;       // magnitude being shifted out into the BCD register
    logic [BCDW-1:0] bcd_q, bcd_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            load_out;
    logic [3:0]      dig_q [NDIG];

    logic [BITS-1:0] abs_in;
    logic [BCDW-1:0] bcd_adj;
    logic [BCDW-1:0] bcd_shift;
    logic [BITS-1:0] mag_shift;
    logic            ovf_now;
    logic [3:0]      fmt [NDIG];
    logic [3:0]      ones, tens, hund;

    // Negating the most negative value yields the same bit pattern. Read as
    // unsigned, that pattern is exactly the wanted magnitude (1024 for 11 bits).
    assign abs_in = binin[BITS-1] ? (~binin + 1'b1) : binin;

    // Add-3 correction: any nibble >= 5 would overflow past 9 after doubling.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5)
                                      ? (bcd_q[gi*4 +: 4] + 4'd3)
                                      : bcd_q[gi*4 +: 4];
        end
    endgenerate

    // One step of the joint shift: the magnitude MSB enters the BCD LSB.
    assign {bcd_shift, mag_shift} = {bcd_adj, mag_q} << 1;

    assign ovf_now = ({1'b0, magin_q} > MAXMAG_L);

    // Display formatting of the BCD value produced by the final shift.
    assign ones = bcd_shift[3:0];
    assign tens = bcd_shift[7:4];
    assign hund = bcd_shift[11:8];

    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            fmt[i] = CODE_ERR;
        end
        if (!ovf_now) begin
            fmt[0] = ones;
            fmt[1] = (hund == 4'd0 && tens == 4'd0) ? CODE_BLANK : tens;
            fmt[2] = (hund == 4'd0) ? CODE_BLANK : hund;
            // A zero result never gets a minus sign.
            fmt[3] = (sign_q && magin_q != '0) ? CODE_MINUS : CODE_BLANK;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        magin_d  = magin_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        load_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = binin[BITS-1];
                    magin_d = abs_in;
                    mag_d   = abs_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = bcd_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + 1'b1;
                // The counter still shows BITS-1 on the edge that makes the last shift.
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    ovf_d    = ovf_now;
                    load_out = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            magin_q <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            // Reset display reads "0": ones digit zero, everything else blank.
            dig_q[0] <= 4'd0;
            for (int i = 1; i < NDIG; i++) begin
                dig_q[i] <= CODE_BLANK;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            magin_q <= magin_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (load_out) begin
                for (int i = 0; i < NDIG; i++) begin
                    dig_q[i] <= fmt[i];
                end
            end
        end
    end

    assign busy = (state_q == S_CONV);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign BCD0 = dig_q[0];
    assign BCD1 = dig_q[1];
    assign BCD2 = dig_q[2];
    assign BCD3 = dig_q[3];

endmodule

// File: tb/tb_bintobcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bintobcd_seq
//
// Bench for bintobcd_seq. A cycle-level reference model tracks the accept,
// latency and hold behaviour. It derives the display codes arithmetically
// from the captured value. A compare process checks every output against the
// model on each falling edge. Directed tests add literal expectations for
// latency, formatting, overflow, ignored starts, reset abort and a full
// back-to-back sweep with a BCD-to-binary round trip.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bintobcd_seq;

    localparam int BITS = 11;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [BITS-1:0] binin = '0;
    logic            busy, done, ovf;
    logic [3:0]      BCD0, BCD1, BCD2, BCD3;

    int errors     = 0;
    int checks     = 0;
    int done_count = 0;

    // Reference model state
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_codes = 16'hFFF0;
    int          m_cnt   = 0;
    int          m_val   = 0;

    bintobcd_seq #(.BITS(BITS), .MAXMAG(999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .binin (binin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .BCD0  (BCD0),
        .BCD1  (BCD1),
        .BCD2  (BCD2),
        .BCD3  (BCD3)
    );

    always #5 clk = ~clk;

    // {ovf, BCD3, BCD2, BCD1, BCD0} expected for a value x.
    function automatic logic [16:0] model_codes(input int x);
        int m, d0, d1, d2;
        logic [3:0] b1, b2, b3;
        m = (x < 0) ? -x : x;
        if (m > 999) return {1'b1, 16'hEEEE};
        d0 = m % 10;
        d1 = (m / 10) % 10;
        d2 = m / 100;
        b2 = (d2 == 0) ? 4'hF : 4'(d2);
        b1 = (d2 == 0 && d1 == 0) ? 4'hF : 4'(d1);
        b3 = (x < 0 && m != 0) ? 4'hB : 4'hF;
        return {1'b0, b3, b2, b1, 4'(d0)};
    endfunction

    // BCD-to-binary direction: non-numeric codes count as zero.
    function automatic int dig_val(input logic [3:0] c);
        return (c <= 4'd9) ? int'(c) : 0;
    endfunction

    function automatic int bcd_to_bin(input logic [3:0] b3, input logic [3:0] b2,
                                      input logic [3:0] b1, input logic [3:0] b0);
        int v;
        v = 100 * dig_val(b2) + 10 * dig_val(b1) + dig_val(b0);
        return (b3 == 4'hB) ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: steps on the rising edge, resets asynchronously.
    initial begin : model
        logic [16:0] r;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_ovf   = 1'b0;
                m_codes = 16'hFFF0;
                m_cnt   = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_cnt++;
                    if (m_cnt == BITS) begin
                        r       = model_codes(m_val);
                        m_busy  = 1'b0;
                        m_done  = 1'b1;
                        m_ovf   = r[16];
                        m_codes = r[15:0];
                    end
                end else if (start) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_val  = $signed(binin);
                end
            end
        end
    end

    // Compare process: every output on every falling edge.
    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("codes", int'({BCD3, BCD2, BCD1, BCD0}), int'(m_codes));
            if (done) begin
                done_count++;
                $display("conv x=%0d -> BCD3..0=%h %h %h %h ovf=%0b", m_val, BCD3, BCD2, BCD1, BCD0, ovf);
                if (m_val >= -999 && m_val <= 999)
                    chk("roundtrip", bcd_to_bin(BCD3, BCD2, BCD1, BCD0), m_val);
            end
        end
    end

    // One conversion with a single-cycle start pulse; checks latency and a literal result.
    task automatic convert(input int x, input string name, input logic [16:0] exp_lit);
        int lat;
        @(negedge clk);
        start = 1'b1;
        binin = BITS'(x);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        // Start taken on edge k; done is seen on the falling edge after edge k+BITS.
        chk({name, "_latency"}, lat, BITS + 1);
        chk({name, "_result"}, int'({ovf, BCD3, BCD2, BCD1, BCD0}), int'(exp_lit));
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int dc0, n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_codes", int'({BCD3, BCD2, BCD1, BCD0}), 16'hFFF0);

        // Pin the model with hand-computed codes.
        chk("model_0", int'(model_codes(0)), 17'h0FFF0);
        chk("model_509", int'(model_codes(509)), 17'h0F509);
        chk("model_m7", int'(model_codes(-7)), 17'h0BFF7);
        chk("model_1000", int'(model_codes(1000)), 17'h1EEEE);
        chk("model_m40", int'(model_codes(-40)), 17'h0BF40);

        // Zero, inner zero, negative, range edges.
        convert(0, "zero", 17'h0FFF0);
        convert(509, "p509", 17'h0F509);
        convert(-7, "m7", 17'h0BFF7);
        convert(999, "p999", 17'h0F999);
        convert(1000, "p1000", 17'h1EEEE);
        convert(-1024, "m1024", 17'h1EEEE);
        convert(-999, "m999", 17'h0B999);

        // Reset in the middle of a conversion of 123.
        @(negedge clk);
        start = 1'b1;
        binin = BITS'(123);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dc0 = done_count;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_codes", int'({BCD3, BCD2, BCD1, BCD0}), 16'hFFF0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("abort_no_done", done_count - dc0, 0);
        convert(123, "p123", 17'h0F123);

        // Extra start pulse and binin changes while busy are ignored.
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1;
        binin = BITS'(200);
        @(negedge clk);
        start = 1'b0;
        binin = BITS'(-55);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        binin = BITS'(77);
        repeat (30) @(negedge clk);
        #1;
        chk("busy_start_dones", done_count - dc0, 1);
        chk("busy_start_result", int'({ovf, BCD3, BCD2, BCD1, BCD0}), 17'h0F200);

        // start held high: full sweep, one result per BITS+1 cycles.
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1;
        binin = BITS'(-1024);
        for (int v = -1024; v <= 1023; v++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            chk("sweep_interval", n, BITS + 1);
            if (!done) break;
            if (v < 1023) binin = BITS'(v + 1);
            else start = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("sweep_dones", done_count - dc0, 2048);
        repeat (20) @(negedge clk);
        #1;
        chk("sweep_no_extra", done_count - dc0, 2048);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
